audio_adc_deserializer: RTL and testbench
=========================================

# audio_adc_deserializer

Capture-side counterpart of the audio DAC path: receives serial stereo PCM from the codec ADC (I2S framing, codec is bit/word-clock master) and delivers complete left/right sample pairs to the Nios II audio subsystem through a valid/ready stream. All logic runs in the clk_clk domain; BCLK, ADCLRCK and ADCDAT are treated as asynchronous inputs and oversampled. A small frame FIFO absorbs software/DMA latency; overflow and malformed-word conditions are reported through sticky status flags.

## Interface
- DATA_WIDTH, 24: bits per channel word captured MSB-first (valid 16..32).
- FIFO_DEPTH, 4: stereo frames buffered; power of two, ≥2.
- clk_clk  in  1  system clock, all state on rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- audio_adc_BCLK  in  1  codec bit clock, asynchronous.
- audio_adc_ADCLRCK  in  1  codec word clock, asynchronous; 0 = left, 1 = right.
- audio_adc_ADCDAT  in  1  codec serial data, asynchronous.
- out_valid  out  1  FIFO head holds a frame.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_left  out  DATA_WIDTH  left sample of head frame.
- out_right  out  DATA_WIDTH  right sample of head frame.
- fill_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- overflow  out  1  sticky: a frame was dropped because FIFO full.
- short_word  out  1  sticky: LRCK toggled before DATA_WIDTH bits captured.
- clr_status  in  1  synchronous clear of overflow and short_word.

## Operation
- Input conditioning: BCLK, ADCLRCK, ADCDAT each pass two sync flops; BCLK has a third flop; bclk_rise = sync2 & ~sync3. LRCK and DAT are sampled from their sync2 stage on bclk_rise (equal delay, aligned).
- Alignment: first bclk_rise after reset only loads lrck_q (lrck_known=1); no capture until an LRCK transition is then seen.
- Word FSM, states IDLE, SKIP, SHIFT, evaluated only on bclk_rise:
  - Any state, lrck ≠ lrck_q: lrck_q←lrck, chan←lrck, bit_cnt←0, go SKIP (this bit is the previous word's LSB slot in I2S; not shifted). If leaving SHIFT with bit_cnt<DATA_WIDTH: word discarded, short_word←1.
  - SKIP: next rise → SHIFT, shift first (MSB) bit, bit_cnt←1.
  - SHIFT: shift ADCDAT into LSB, bit_cnt+1; at bit_cnt=DATA_WIDTH word complete → IDLE. Extra bits until next LRCK edge ignored.
- Word complete, chan=0: left_hold←word, left_ok←1. chan=1: if left_ok, push {left_hold, word} next cycle, left_ok←0; if not left_ok, right word dropped silently (partial first frame).
- FIFO: first-word-fall-through; out_left/out_right show head whenever out_valid. Pop on out_valid & out_ready.
  - Push while full and no pop: frame dropped, overflow←1, contents unchanged.
  - Push while full with pop same cycle: both occur, fill_level unchanged.
  - Push while empty: out_valid rises next cycle (no bypass).
- clr_status clears sticky flags; if a set event coincides, set wins.
- Reset (any time, incl. mid-word): FSM IDLE, lrck_known=0, left_ok=0, FIFO emptied, all outputs 0; partial word lost; realignment as after power-up.

## Timing
- Requires BCLK high and low phases ≥2 clk_clk periods each (e.g. 50 MHz clk, BCLK ≤12.5 MHz; WM8731 at 48 kHz/64 fs = 3.072 MHz).
- Let edge k be the first clk_clk edge sampling BCLK pin high: sync2=1 after k+1, bit shifted/word complete registered at k+2, FIFO written at k+3, out_valid=1 after k+3.
- Pop: head advances at the accepting edge; next frame visible the following cycle.
- fill_level, overflow, short_word registered; update at the edge of the causing event.
- No combinational path from any input to any output.

## Test plan
- Reset values: assert reset_reset mid-stream -> out_valid=0, fill_level=0, overflow=0, short_word=0, out_left/out_right=0 within same cycle.
- Basic frame: DATA_WIDTH=24, BCLK=clk/8, 32 BCLK per channel, left=0xA5A5A5, right=0x5A5A5A -> one frame, out_left=0xA5A5A5, out_right=0x5A5A5A, out_valid exactly 3 clk after right LSB BCLK rise detection edge k.
- Startup alignment: reset released mid-right-word -> first partial right word dropped, first frame delivered is next full left/right pair.
- Overflow: out_ready=0, send 5 frames (0x000001..0x000005 both channels) -> fill_level=4, overflow=1, reads yield frames 1..4; clr_status -> overflow=0.
- Full with simultaneous pop: FIFO full, out_ready=1 during push cycle -> no overflow, fill_level stays 4, order preserved.
- Short word: LRCK toggles after 20 bits of left -> short_word=1, no frame pushed for that pair; next complete pair delivered normally.

Source files
------------

// File: rtl/audio_adc_deserializer_if.sv
// Stream port carrying complete stereo frames out of the ADC deserializer.
// The producer drives valid/left/right; the consumer drives ready.
interface audio_adc_deserializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;

  modport master (output out_valid, output out_left, output out_right, input out_ready);
  modport slave  (input out_valid, input out_left, input out_right, output out_ready);
endinterface

// File: rtl/audio_adc_deserializer.sv
// I2S capture path: oversamples the codec BCLK/ADCLRCK/ADCDAT pins, assembles
// MSB-first channel words, pairs left+right into frames and buffers them in a
// small first-word-fall-through FIFO feeding a valid/ready stream.
module audio_adc_deserializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          audio_adc_BCLK,
  input  logic                          audio_adc_ADCLRCK,
  input  logic                          audio_adc_ADCDAT,
  audio_adc_deserializer_if.master      out_st,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          short_word,
  input  logic                          clr_status
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT} state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning. BCLK carries an extra flop for edge detection; LRCK and
  // DAT are taken from their second stage so all three see the same latency.
  // ---------------------------------------------------------------------------
  logic [2:0] bclk_sync_q;
  logic [1:0] lrck_sync_q;
  logic [1:0] dat_sync_q;
  logic       bclk_rise;
  logic       lrck_s;
  logic       dat_s;

  // Synchronizer chains for the asynchronous codec pins
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], audio_adc_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], audio_adc_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[0], audio_adc_ADCDAT};
    end
  end

  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lrck_s    = lrck_sync_q[1];
  assign dat_s     = dat_sync_q[1];

  // ---------------------------------------------------------------------------
  // Word FSM. Only advances on a detected BCLK rise. An LRCK change always
  // restarts word capture; the slot carrying the change is the previous word's
  // LSB in I2S framing, so it is skipped.
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic                  lrck_q, lrck_d;
  logic                  lrck_known_q, lrck_known_d;
  logic                  chan_q, chan_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] push_l_q, push_l_d;
  logic [DATA_WIDTH-1:0] push_r_q, push_r_d;
  logic                  short_set;
  logic [DATA_WIDTH-1:0] word_next;

  assign word_next = {shift_q, dat_s};

  // FSM and capture registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      lrck_q       <= 1'b0;
      lrck_known_q <= 1'b0;
      chan_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      push_q       <= 1'b0;
      push_l_q     <= '0;
      push_r_q     <= '0;
    end else begin
      state_q      <= state_d;
      lrck_q       <= lrck_d;
      lrck_known_q <= lrck_known_d;
      chan_q       <= chan_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_ok_q    <= left_ok_d;
      push_q       <= push_d;
      push_l_q     <= push_l_d;
      push_r_q     <= push_r_d;
    end
  end

  // Next-state: alignment, word shifting, left/right pairing
  always_comb begin
    state_d      = state_q;
    lrck_d       = lrck_q;
    lrck_known_d = lrck_known_q;
    chan_d       = chan_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    left_ok_d    = left_ok_q;
    push_d       = 1'b0;
    push_l_d     = push_l_q;
    push_r_d     = push_r_q;
    short_set    = 1'b0;

    if (bclk_rise) begin
      if (!lrck_known_q) begin
        // First rise after reset only learns the current channel phase; the
        // word in flight is of unknown length and never captured.
        lrck_d       = lrck_s;
        lrck_known_d = 1'b1;
      end else if (lrck_s != lrck_q) begin
        lrck_d    = lrck_s;
        chan_d    = lrck_s;
        bit_cnt_d = '0;
        state_d   = SKIP;
        // Still in SHIFT means fewer than DATA_WIDTH bits arrived; the
        // partial word is simply abandoned.
        if (state_q == SHIFT) short_set = 1'b1;
      end else begin
        unique case (state_q)
          SKIP: begin
            shift_d   = word_next[DATA_WIDTH-2:0];
            bit_cnt_d = CW'(1);
            state_d   = SHIFT;
          end
          SHIFT: begin
            shift_d   = word_next[DATA_WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CNT_LAST) begin
              state_d = IDLE;
              if (!chan_q) begin
                left_hold_d = word_next;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                push_d    = 1'b1;
                push_l_d  = left_hold_q;
                push_r_d  = word_next;
                left_ok_d = 1'b0;
              end
              // Right word with no pending left is dropped (partial frame).
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO, first-word-fall-through. A push into a full FIFO only succeeds
  // when the head is popped in the same cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  short_q, short_d;
  logic                  fifo_full;
  logic                  fifo_valid;
  logic                  pop;
  logic                  wr_en;

  assign fifo_full  = (count_q == DEPTH_L);
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & out_st.out_ready;
  assign wr_en      = push_q & (~fifo_full | pop);

  // Frame storage; contents need no reset since visibility is gated by count
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem_l[wr_ptr_q] <= push_l_q;
      mem_r[wr_ptr_q] <= push_r_q;
    end
  end

  // FIFO pointers, occupancy and sticky status flags
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  // Occupancy bookkeeping; a set event beats a coincident clear
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    short_d    = short_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !wr_en) count_d = count_q - (AW + 1)'(1);

    if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    else if (clr_status)             overflow_d = 1'b0;

    if (short_set)       short_d = 1'b1;
    else if (clr_status) short_d = 1'b0;
  end

  assign out_st.out_valid = fifo_valid;
  assign out_st.out_left  = fifo_valid ? mem_l[rd_ptr_q] : '0;
  assign out_st.out_right = fifo_valid ? mem_r[rd_ptr_q] : '0;
  assign fill_level       = count_q;
  assign overflow         = overflow_q;
  assign short_word       = short_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Directed bench for the I2S ADC deserializer: drives codec pins at clk/8,
// queues expected frames as they are sent and checks them as the stream pops.
module tb_audio_adc_deserializer;
  localparam int W     = 24;
  localparam int D     = 4;
  localparam int SLOTS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrck = 1'b0;
  logic dat = 1'b0;
  logic clr = 1'b0;
  logic [$clog2(D):0] fill;
  logic ovf;
  logic shw;

  audio_adc_deserializer_if #(.DATA_WIDTH(W)) st ();

  audio_adc_deserializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .audio_adc_BCLK   (bclk),
    .audio_adc_ADCLRCK(lrck),
    .audio_adc_ADCDAT (dat),
    .out_st           (st),
    .fill_level       (fill),
    .overflow         (ovf),
    .short_word       (shw),
    .clr_status       (clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted frame must match the head of the queue
  always @(negedge clk) begin
    if (st.out_valid === 1'b1 && st.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk(64'(exp_q.size()), 64'd1, "unexpected_frame");
      else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        chk(64'({st.out_left, st.out_right}), 64'(e), "frame");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One BCLK period (4 clk low, 4 clk high). mode 1: check out_valid latency
  // relative to the rise; mode 2: hold out_ready only across the FIFO write edge.
  task automatic send_bit(input logic lr, input logic d, input int mode);
    lrck = lr;
    dat  = d;
    repeat (4) tick();
    bclk = 1'b1;
    if (mode == 1) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk(64'(st.out_valid), 64'd0, "lat_early");
      end
      @(negedge clk);
      chk(64'(st.out_valid), 64'd1, "lat_k3");
    end else if (mode == 2) begin
      repeat (3) tick();
      st.out_ready = 1'b1;
      tick();
      st.out_ready = 1'b0;
    end
    repeat (4) tick();
    bclk = 1'b0;
  endtask

  task automatic send_channel(input logic lr, input logic [W-1:0] word, input int nslots,
                              input int mode);
    for (int s = 0; s < nslots; s++) begin
      logic d;
      d = (s >= 1 && s <= W) ? word[W-s] : 1'b0;
      send_bit(lr, d, (s == W) ? mode : 0);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit expect_it,
                            input int mode);
    if (expect_it) exp_q.push_back({l, r});
    send_channel(1'b0, l, SLOTS, 0);
    send_channel(1'b1, r, SLOTS, mode);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    st.out_ready = 1'b1;
    while ((exp_q.size() != 0 || st.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(64'(exp_q.size()), 64'd0, tag);
    repeat (2) @(negedge clk);
    chk(64'(fill), 64'd0, tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(64'(st.out_valid), 64'd0, tag);
    chk(64'(fill), 64'd0, tag);
    chk(64'(ovf), 64'd0, tag);
    chk(64'(shw), 64'd0, tag);
    chk(64'(st.out_left), 64'd0, tag);
    chk(64'(st.out_right), 64'd0, tag);
  endtask

  initial begin
    st.out_ready = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset_values");

    // Startup: reset released in the middle of a right word
    st.out_ready = 1'b1;
    for (int s = 0; s < 10; s++) send_bit(1'b1, 1'b1, 0);
    rst = 1'b0;
    for (int s = 10; s < SLOTS; s++) send_bit(1'b1, 1'b1, 0);
    send_frame(24'h123456, 24'h654321, 1'b1, 0);
    drain("startup_drain");

    // Basic frame with exact latency from the right LSB rise
    st.out_ready = 1'b0;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1);
    chk(64'(fill), 64'd1, "basic_fill");
    chk(64'(st.out_left), 64'hA5A5A5, "basic_left");
    chk(64'(st.out_right), 64'h5A5A5A, "basic_right");
    drain("basic_drain");

    // Overflow: five frames into a four-deep FIFO with no consumer
    st.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(W'(i), W'(i), (i <= 4), 0);
    chk(64'(fill), 64'd4, "ovf_fill");
    chk(64'(ovf), 64'd1, "ovf_flag");
    chk(64'(st.out_left), 64'd1, "ovf_head");
    drain("ovf_drain");
    chk(64'(ovf), 64'd1, "ovf_sticky");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk(64'(ovf), 64'd0, "ovf_clear");

    // Full FIFO with a pop on the same edge as the push
    st.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(W'(24'h10 + i), W'(24'h20 + i), 1'b1, 0);
    chk(64'(fill), 64'd4, "fp_fill_before");
    send_frame(24'h14, 24'h24, 1'b1, 2);
    chk(64'(fill), 64'd4, "fp_fill_after");
    chk(64'(ovf), 64'd0, "fp_no_ovf");
    chk(64'(st.out_left), 64'h11, "fp_head");
    drain("fp_drain");

    // Short left word: pair dropped, flag set, next pair delivered
    st.out_ready = 1'b1;
    send_channel(1'b0, 24'hFFFFFF, 21, 0);
    send_channel(1'b1, 24'hABCDEF, SLOTS, 0);
    chk(64'(shw), 64'd1, "short_flag");
    chk(64'(fill), 64'd0, "short_no_frame");
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1, 0);
    drain("short_drain");
    chk(64'(shw), 64'd1, "short_sticky");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk(64'(shw), 64'd0, "short_clear");

    // Reset mid-stream with a frame buffered and a left word in flight
    st.out_ready = 1'b0;
    send_frame(24'h111111, 24'h222222, 1'b0, 0);
    chk(64'(fill), 64'd1, "mid_fill");
    send_channel(1'b0, 24'h333333, 10, 0);
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    for (int s = 0; s < 5; s++) send_bit(1'b1, 1'b0, 0);
    rst = 1'b0;
    st.out_ready = 1'b1;
    for (int s = 5; s < SLOTS; s++) send_bit(1'b1, 1'b0, 0);
    send_frame(24'h444444, 24'h555555, 1'b1, 0);
    drain("realign_drain");

    // Random frames streamed straight through
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] l, r;
      l = W'($urandom);
      r = W'($urandom);
      send_frame(l, r, 1'b1, 0);
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
